// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer with selectable presets, pause/resume, clear and a 4-digit 7-seg scan.
// Define TIMER_BLINK_EN to blink the display and LEDs while in DONE.
module countdown_timer_mmss #(
    parameter int          TICK_DIV  = 100_000_000,
    parameter int          SCAN_BITS = 16,
    parameter int          N_PRESETS = 2,
    parameter logic [15:0] PRESET0   = 16'h0025,
    parameter logic [15:0] PRESET1   = 16'h0130,
    parameter logic [15:0] PRESET2   = 16'h0500,
    parameter logic [15:0] PRESET3   = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pulse,
    input  logic        mode_pulse,
    input  logic        clear_pulse,
    output logic [3:0]  DIGIT,
    output logic [7:0]  DISPLAY,
    output logic [15:0] led,
    output logic        done
);

    // state | meaning
    // IDLE  | preset loaded, waiting for start
    // RUN   | counting down once per tick
    // PAUSE | count and partial second frozen
    // DONE  | reached 00:00, waiting for acknowledge

`ifdef TIMER_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [1:0]    IDX_MAX = 2'(N_PRESETS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t               state, state_n;
    logic [1:0]           idx, idx_n;
    logic [15:0]          count, count_n, count_dec;
    logic [PW-1:0]        presc, presc_n;
    logic [SCAN_BITS-1:0] scan;
    logic                 phase, phase_n;
    logic                 presc_en, tick;
    logic [1:0]           sel;
    logic [3:0]           nib;
    logic [7:0]           seg;

    function automatic logic [15:0] preset_of(input logic [1:0] i);
        case (i)
            2'd0:    preset_of = PRESET0;
            2'd1:    preset_of = PRESET1;
            2'd2:    preset_of = PRESET2;
            default: preset_of = PRESET3;
        endcase
    endfunction

    assign presc_en = (state == RUN) || (BLINK_EN && (state == DONE));
    assign tick     = presc_en && (presc == PRE_MAX);

    // BCD decrement with borrow chain s0 -> s1 (base 6) -> m0 -> m1
    always_comb begin
        count_dec = count;
        if (count[3:0] != 4'd0) begin
            count_dec[3:0] = count[3:0] - 4'd1;
        end else begin
            count_dec[3:0] = 4'd9;
            if (count[7:4] != 4'd0) begin
                count_dec[7:4] = count[7:4] - 4'd1;
            end else begin
                count_dec[7:4] = 4'd5;
                if (count[11:8] != 4'd0) begin
                    count_dec[11:8] = count[11:8] - 4'd1;
                end else begin
                    count_dec[11:8]  = 4'd9;
                    count_dec[15:12] = count[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        count_n = count;
        presc_n = presc;
        phase_n = phase;
        if (clear_pulse) begin
            state_n = IDLE;
            count_n = preset_of(idx);
            presc_n = '0;
        end else if (mode_pulse) begin
            idx_n   = (idx == IDX_MAX) ? 2'd0 : idx + 2'd1;
            state_n = IDLE;
            count_n = preset_of(idx_n);
            presc_n = '0;
        end else if (start_pulse) begin
            case (state)
                IDLE:  state_n = (count == 16'h0000) ? DONE : RUN;
                RUN:   state_n = PAUSE;
                PAUSE: state_n = RUN;
                DONE: begin
                    state_n = IDLE;
                    count_n = preset_of(idx);
                    presc_n = '0;
                end
                default: state_n = IDLE;
            endcase
        end else if (presc_en) begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (tick && (state == RUN)) begin
                count_n = count_dec;
                if (count_dec == 16'h0000) state_n = DONE;
            end
            if (tick && (state == DONE)) phase_n = ~phase;
        end
        if (state_n != DONE) phase_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            count <= PRESET0;
            presc <= '0;
            scan  <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            count <= count_n;
            presc <= presc_n;
            scan  <= scan + 1'b1;
            phase <= phase_n;
        end
    end

    assign sel = scan[SCAN_BITS-1 -: 2];

    always_comb begin
        case (sel)
            2'd0:    begin nib = count[3:0];   DIGIT = 4'b1110; end
            2'd1:    begin nib = count[7:4];   DIGIT = 4'b1101; end
            2'd2:    begin nib = count[11:8];  DIGIT = 4'b1011; end
            default: begin nib = count[15:12]; DIGIT = 4'b0111; end
        endcase
        case (nib)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = 8'hFF;
        endcase
        DISPLAY = seg;
        if (sel == 2'd2) DISPLAY[0] = 1'b0;
        done = (state == DONE);
        led  = 16'h0000;
        if (state == DONE) begin
            led = 16'hFFFF;
        end else begin
            led[idx] = 1'b1;
            led[15]  = (state == RUN);
        end
        if (BLINK_EN && phase) begin
            DIGIT = 4'b1111;
            led   = 16'h0000;
        end
    end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Bench for countdown_timer_mmss: seconds-based reference model checked every cycle plus directed literals.
module tb_countdown_timer_mmss;

    localparam int TD = 4;
    localparam int SB = 4;
    localparam int NP = 2;
    localparam logic [15:0] PRE [4] = '{16'h0025, 16'h0130, 16'h0500, 16'h1000};
    localparam logic [7:0]  SEG [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                         8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

`ifdef TIMER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start_pulse, mode_pulse, clear_pulse;
    logic [3:0]  DIGIT;
    logic [7:0]  DISPLAY;
    logic [15:0] led;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int m_state = 0, m_idx = 0, m_secs = 0, m_pre = 0, m_ph = 0, m_scan = 0;

    always #5 clk = ~clk;

    countdown_timer_mmss #(
        .TICK_DIV(TD), .SCAN_BITS(SB), .N_PRESETS(NP),
        .PRESET0(PRE[0]), .PRESET1(PRE[1]), .PRESET2(PRE[2]), .PRESET3(PRE[3])
    ) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .mode_pulse(mode_pulse),
        .clear_pulse(clear_pulse), .DIGIT(DIGIT), .DISPLAY(DISPLAY), .led(led), .done(done)
    );

    function automatic int bcd2s(input logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Reference model: the count is held as plain seconds, the second as an elapsed-cycle count.
    always @(posedge clk) begin : model
        int st, ix, secs, pre, ph;
        st = m_state; ix = m_idx; secs = m_secs; pre = m_pre; ph = m_ph;
        if (rst) begin
            st = M_IDLE; ix = 0; secs = bcd2s(PRE[0]); pre = 0; ph = 0;
            m_scan <= 0;
        end else begin
            m_scan <= (m_scan + 1) % (1 << SB);
            if (clear_pulse) begin
                st = M_IDLE; secs = bcd2s(PRE[ix]); pre = 0;
            end else if (mode_pulse) begin
                ix = (ix + 1) % NP; st = M_IDLE; secs = bcd2s(PRE[ix]); pre = 0;
            end else if (start_pulse) begin
                if (st == M_IDLE)       st = (secs == 0) ? M_DONE : M_RUN;
                else if (st == M_RUN)   st = M_PAUSE;
                else if (st == M_PAUSE) st = M_RUN;
                else begin
                    st = M_IDLE; secs = bcd2s(PRE[ix]); pre = 0;
                end
            end else if (st == M_RUN || (BLINK && st == M_DONE)) begin
                pre = pre + 1;
                if (pre == TD) begin
                    pre = 0;
                    if (st == M_RUN) begin
                        secs = secs - 1;
                        if (secs == 0) st = M_DONE;
                    end else begin
                        ph = 1 - ph;
                    end
                end
            end
            if (st != M_DONE) ph = 0;
        end
        m_state <= st; m_idx <= ix; m_secs <= secs; m_pre <= pre; m_ph <= ph;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int sel, mm, ss;
        int dg [4];
        logic [3:0]  ed;
        logic [7:0]  es;
        logic [15:0] el;
        sel = m_scan / (1 << (SB - 2));
        mm = m_secs / 60;
        ss = m_secs % 60;
        dg[0] = ss % 10; dg[1] = ss / 10; dg[2] = mm % 10; dg[3] = mm / 10;
        ed = 4'hF;
        ed[sel] = 1'b0;
        es = SEG[dg[sel]];
        if (sel == 2) es[0] = 1'b0;
        if (m_state == M_DONE) el = 16'hFFFF;
        else begin
            el = 16'h0000;
            el[m_idx] = 1'b1;
            el[15] = (m_state == M_RUN);
        end
        if (BLINK && m_ph != 0) begin
            ed = 4'hF;
            el = 16'h0000;
        end
        chk("model_DIGIT", DIGIT, ed);
        chk("model_DISPLAY", DISPLAY, es);
        chk("model_led", led, el);
        chk("model_done", done, (m_state == M_DONE));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 1 start, 2 mode, 4 clear (bitwise)
    task automatic pulse(input int which);
        start_pulse = which[0];
        mode_pulse  = which[1];
        clear_pulse = which[2];
        @(negedge clk);
        start_pulse = 1'b0;
        mode_pulse  = 1'b0;
        clear_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_pulse = 1'b0; mode_pulse = 1'b0; clear_pulse = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) compare_all();
            end
        join_none
        @(negedge clk);
        chk_en = 1'b1;
        cyc(2);
        chk("rst_DIGIT", DIGIT, 4'b1110);
        chk("rst_DISPLAY", DISPLAY, 8'h49);
        chk("rst_led", led, 16'h0001);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // idle scan
        cyc(4);  chk("idle_DIGIT1", DIGIT, 4'b1101); chk("idle_DISP1", DISPLAY, 8'h25);
        cyc(4);  chk("idle_DIGIT2", DIGIT, 4'b1011); chk("idle_DISP2", DISPLAY, 8'h02);
        cyc(4);  chk("idle_DIGIT3", DIGIT, 4'b0111); chk("idle_DISP3", DISPLAY, 8'h03);
        cyc(8);  chk("idle_secs", m_secs, 25);

        // run 00:25 to completion
        pulse(1);
        cyc(3);  chk("run_first_pre", m_secs, 25);
        cyc(1);  chk("run_first_dec", m_secs, 24);
        cyc(19); chk("run_0020", m_secs, 20);
        cyc(1);  chk("run_0019", m_secs, 19);
        chk("run_led", led, 16'h8001);
        cyc(75); chk("run_done_pre", done, 1'b0);
        cyc(1);  chk("run_done", done, 1'b1); chk("run_done_led", led, 16'hFFFF);
        cyc(8);  chk("done_hold_secs", m_secs, 0); chk("done_hold", done, 1'b1);

        // acknowledge, next preset, minute borrow
        pulse(1); chk("ack_led", led, 16'h0001);
        pulse(2); chk("mode_led", led, 16'h0002); chk("mode_secs", m_secs, 90);
        pulse(1); chk("mode_run_led", led, 16'h8002);
        cyc(16);  chk("p1_4ticks", m_secs, 86);
        cyc(108); chk("p1_31ticks", m_secs, 59);

        // pause / resume keeps partial second
        pulse(4); chk("clr_secs", m_secs, 90);
        pulse(1);
        cyc(2);
        pulse(1); chk("pause_led", led, 16'h0002);
        cyc(50);  chk("pause_secs", m_secs, 90);
        pulse(1); chk("resume_led", led, 16'h8002);
        cyc(1);   chk("resume_1", m_secs, 90);
        cyc(1);   chk("resume_2", m_secs, 89);

        // clear beats start in the same cycle
        pulse(5); chk("clrstart_led", led, 16'h0002); chk("clrstart_done", done, 1'b0);
        chk("clrstart_secs", m_secs, 90);
        pulse(1);
        cyc(3);   chk("clr_pre_reset", m_secs, 90);
        cyc(1);   chk("clr_pre_tick", m_secs, 89);
        pulse(2); chk("wrap_led", led, 16'h0001); chk("wrap_secs", m_secs, 25);

        // reset mid-count
        pulse(1);
        cyc(6);   chk("mid_secs", m_secs, 24);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_DISPLAY", DISPLAY, 8'h49);
        chk("midrst_DIGIT", DIGIT, 4'b1110);
        chk("midrst_led", led, 16'h0001);
        chk("midrst_secs", m_secs, 25);

        // DONE display behaviour and acknowledge
        pulse(1);
        cyc(100); chk("d2_done", done, 1'b1); chk("d2_led", led, 16'hFFFF);
`ifdef TIMER_BLINK_EN
        cyc(4);   chk("blink_DIGIT", DIGIT, 4'b1111); chk("blink_led", led, 16'h0000);
        cyc(4);   chk("blink_off_led", led, 16'hFFFF);
`else
        cyc(4);   chk("steady_led1", led, 16'hFFFF);
        cyc(4);   chk("steady_led2", led, 16'hFFFF);
`endif
        chk("d2_done_hold", done, 1'b1);
        pulse(1); chk("d2_ack_led", led, 16'h0001); chk("d2_ack_done", done, 1'b0);
        chk("d2_ack_secs", m_secs, 25);
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
